mem_ctrl: RTL

Byte-serial memory controller between the core and the single byte-wide RAM/IO port. Responds to instruction-cache line-fill requests from the fetch unit with a full 64-byte line. Serves 1/2/4-byte loads and stores for the load/store buffer. Arbitrates between the two requesters, sequences per-byte addresses, and stalls IO writes while the IO buffer is full.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: widths, line size,
// FSM states, length decode and the IO address-range test.
package mem_ctrl_pkg;

  localparam int ADDR_WID        = 32;
  localparam int LINE_BYTES      = 64;
  localparam int ICACHE_LINE_WID = 8 * LINE_BYTES;
  localparam int CNT_WID         = 7;
  localparam logic [1:0] IO_RANGE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    IFETCH,
    LOAD,
    STORE
  } state_t;

  // Encoding 3 is not a legal size; it is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] addr_hi);
    return addr_hi == IO_RANGE;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bus between the fetch unit, the load/store buffer, the
// byte-wide RAM port and the memory controller.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                       if_en;
  logic [ADDR_WID-1:0]        if_pc;
  logic                       if_done;
  logic [ICACHE_LINE_WID-1:0] if_data;

  logic                       lsb_en;
  logic                       lsb_wr;
  logic [ADDR_WID-1:0]        lsb_addr;
  logic [1:0]                 lsb_len;
  logic [31:0]                lsb_wdata;
  logic                       lsb_done;
  logic [31:0]                lsb_rdata;

  logic [7:0]                 ram_din;
  logic [7:0]                 ram_dout;
  logic [ADDR_WID-1:0]        ram_a;
  logic                       ram_wr;

  modport slave (
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata, ram_din,
    output if_done, if_data, lsb_done, lsb_rdata, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata, ram_din,
    input  if_done, if_data, lsb_done, lsb_rdata, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates I-cache line fills and LSB
// loads/stores onto a single byte-wide RAM/IO port.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      rollback,
  input  logic      io_buffer_full,
  mem_ctrl_if.slave bus
);

  state_t                     state, state_nxt;
  logic [CNT_WID-1:0]         cnt, cnt_nxt;
  logic [ADDR_WID-1:0]        ram_a, ram_a_nxt;
  logic                       ram_wr, ram_wr_nxt;
  logic [7:0]                 ram_dout, ram_dout_nxt;
  logic                       if_done, if_done_nxt;
  logic [ICACHE_LINE_WID-1:0] if_data, if_data_nxt;
  logic                       lsb_done, lsb_done_nxt;
  logic [31:0]                lsb_rdata, lsb_rdata_nxt;
  logic [2:0]                 len, len_nxt;
  logic [31:0]                wdata, wdata_nxt;

  logic [5:0] fill_idx;
  logic [1:0] load_idx;
  logic [1:0] store_idx;
  logic       io_stall;
  logic       lsb_accept;

  // RAM data lags the address by one cycle, so the byte landing now belongs to cnt-1.
  assign fill_idx   = cnt[5:0] - 6'd1;
  assign load_idx   = cnt[1:0] - 2'd1;
  assign store_idx  = cnt[1:0] + 2'd1;
  assign io_stall   = is_io(ram_a[17:16]) && ram_wr && io_buffer_full;
  assign lsb_accept = bus.lsb_en && (bus.lsb_wr || !rollback);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ram_a_nxt     = ram_a;
    ram_wr_nxt    = ram_wr;
    ram_dout_nxt  = ram_dout;
    if_done_nxt   = 1'b0;
    if_data_nxt   = if_data;
    lsb_done_nxt  = 1'b0;
    lsb_rdata_nxt = lsb_rdata;
    len_nxt       = len;
    wdata_nxt     = wdata;

    case (state)
      IDLE: begin
        ram_wr_nxt = 1'b0;
        // Done still high means the requester has not yet seen it; do not re-accept.
        if (!if_done && !lsb_done) begin
          if (lsb_accept) begin
            cnt_nxt   = '0;
            ram_a_nxt = bus.lsb_addr;
            len_nxt   = len_bytes(bus.lsb_len);
            wdata_nxt = bus.lsb_wdata;
            if (bus.lsb_wr) begin
              ram_wr_nxt   = 1'b1;
              ram_dout_nxt = bus.lsb_wdata[7:0];
              state_nxt    = STORE;
            end else begin
              lsb_rdata_nxt = '0;
              state_nxt     = LOAD;
            end
          end else if (bus.if_en) begin
            cnt_nxt   = '0;
            ram_a_nxt = bus.if_pc;
            state_nxt = IFETCH;
          end
        end
      end

      IFETCH: begin
        if (cnt != '0)
          if_data_nxt[{fill_idx, 3'b000} +: 8] = bus.ram_din;
        if (cnt == CNT_WID'(LINE_BYTES)) begin
          if_done_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt   = cnt + 7'd1;
          ram_a_nxt = ram_a + 32'd1;
        end
      end

      LOAD: begin
        if (rollback) begin
          ram_wr_nxt = 1'b0;
          state_nxt  = IDLE;
        end else begin
          if (cnt != '0)
            lsb_rdata_nxt[{load_idx, 3'b000} +: 8] = bus.ram_din;
          if (cnt == CNT_WID'(len)) begin
            lsb_done_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            cnt_nxt   = cnt + 7'd1;
            ram_a_nxt = ram_a + 32'd1;
          end
        end
      end

      STORE: begin
        if (!io_stall) begin
          if (cnt == CNT_WID'(len - 3'd1)) begin
            ram_wr_nxt   = 1'b0;
            lsb_done_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            cnt_nxt      = cnt + 7'd1;
            ram_a_nxt    = ram_a + 32'd1;
            ram_dout_nxt = wdata[{store_idx, 3'b000} +: 8];
          end
        end
      end

      default: begin
        ram_wr_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
      len       <= '0;
      wdata     <= '0;
    end else if (rdy) begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ram_a     <= ram_a_nxt;
      ram_wr    <= ram_wr_nxt;
      ram_dout  <= ram_dout_nxt;
      if_done   <= if_done_nxt;
      if_data   <= if_data_nxt;
      lsb_done  <= lsb_done_nxt;
      lsb_rdata <= lsb_rdata_nxt;
      len       <= len_nxt;
      wdata     <= wdata_nxt;
    end
  end

  assign bus.if_done   = if_done;
  assign bus.if_data   = if_data;
  assign bus.lsb_done  = lsb_done;
  assign bus.lsb_rdata = lsb_rdata;
  assign bus.ram_a     = ram_a;
  assign bus.ram_wr    = ram_wr;
  assign bus.ram_dout  = ram_dout;

endmodule
